goertzel_filter: RTL and testbench

- Goertzel single-bin DFT engine; sits directly downstream of the periodic enable generator.
- Consumes its one-cycle sample strobe (`en_in`) together with the ADC sample bus.
- Runs the second-order recursion over N samples, then computes bin power on a snapshot while the next block accumulates.
- Result goes to the tone-detect/threshold logic with a one-cycle valid pulse.

---
 rtl/goertzel_filter.sv | 179 +++++++++++++++++
 tb/tb_goertzel_filter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_filter.sv
// Single-bin Goertzel engine: second-order recursion over N strobed samples,
// then bin power on a snapshot via one shared multiplier while the next block runs.
module goertzel_filter #(
  parameter int DATA_W    = 12,
  parameter int COEFF_W   = 16,
  parameter int COEFF_F   = 14,
  parameter int ACC_W     = 32,
  parameter int N         = 205,
  parameter int POW_W     = 32,
  parameter int POW_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_in,
  input  logic signed [DATA_W-1:0]  sample_in,
  input  logic signed [COEFF_W-1:0] coeff_in,
  output logic [POW_W-1:0]          power_out,
  output logic                      power_valid,
  output logic                      busy
);

  // state | meaning
  // IDLE  | waiting for a completed block
  // P1    | a <= S1*S1
  // P2    | b <= S2*S2
  // P3    | c <= ((C*S1)>>>F)*S2
  // P4    | power = sat((a+b-c)>>>shift), valid pulse
  typedef enum logic [2:0] {IDLE, P1, P2, P3, P4} state_t;

  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = COEFF_W + ACC_W;
  localparam int OP_W   = ACC_W + 2;
  localparam int P_W    = 2 * ACC_W + 2;
  localparam logic signed [P_W-1:0] POW_MAX = {{(P_W-POW_W){1'b0}}, {POW_W{1'b1}}};

  state_t state_q, state_d;
  logic signed [ACC_W-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [COEFF_W-1:0] coeff_q, coeff_d;
  logic signed [ACC_W-1:0]   snap_s1_q, snap_s1_d, snap_s2_q, snap_s2_d;
  logic signed [COEFF_W-1:0] snap_c_q, snap_c_d;
  logic signed [P_W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
  logic [POW_W-1:0]          hold_q, hold_d;

  logic signed [COEFF_W-1:0] coeff_eff;
  logic signed [PROD_W-1:0]  prod_acc;
  logic signed [ACC_W-1:0]   w;
  logic                      last;
  logic signed [PROD_W-1:0]  cs1_full;
  logic signed [OP_W-1:0]    cs1, mul_a, mul_b;
  logic signed [P_W-1:0]     mul, pow_p, pow_shifted;
  logic [POW_W-1:0]          pow_sat;

  // A block start uses the incoming coefficient on its very first sample.
  assign coeff_eff = (cnt_q == '0) ? coeff_in : coeff_q;
  assign prod_acc  = $signed({{ACC_W{coeff_eff[COEFF_W-1]}}, coeff_eff})
                   * $signed({{COEFF_W{s1_q[ACC_W-1]}}, s1_q});
  assign w         = $signed({{(ACC_W-DATA_W){sample_in[DATA_W-1]}}, sample_in})
                   + ACC_W'(prod_acc >>> COEFF_F) - s2_q;
  assign last      = en_in && (cnt_q == CNT_W'(N - 1));
  assign busy      = (cnt_q != '0);

  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    cnt_d     = cnt_q;
    coeff_d   = coeff_q;
    snap_s1_d = snap_s1_q;
    snap_s2_d = snap_s2_q;
    snap_c_d  = snap_c_q;
    if (en_in) begin
      coeff_d = coeff_eff;
      if (last) begin
        s1_d      = '0;
        s2_d      = '0;
        cnt_d     = '0;
        snap_s1_d = w;
        snap_s2_d = s1_q;
        snap_c_d  = coeff_eff;
      end else begin
        s1_d  = w;
        s2_d  = s1_q;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Shared multiplier; operands chosen by the power FSM state.
  assign cs1_full = $signed({{ACC_W{snap_c_q[COEFF_W-1]}}, snap_c_q})
                  * $signed({{COEFF_W{snap_s1_q[ACC_W-1]}}, snap_s1_q});
  assign cs1      = OP_W'(cs1_full >>> COEFF_F);

  always_comb begin
    mul_a = {{2{snap_s1_q[ACC_W-1]}}, snap_s1_q};
    mul_b = {{2{snap_s1_q[ACC_W-1]}}, snap_s1_q};
    case (state_q)
      P2: begin
        mul_a = {{2{snap_s2_q[ACC_W-1]}}, snap_s2_q};
        mul_b = {{2{snap_s2_q[ACC_W-1]}}, snap_s2_q};
      end
      P3: begin
        mul_a = cs1;
        mul_b = {{2{snap_s2_q[ACC_W-1]}}, snap_s2_q};
      end
      default: ;
    endcase
  end

  assign mul = $signed({{(P_W-OP_W){mul_a[OP_W-1]}}, mul_a})
             * $signed({{(P_W-OP_W){mul_b[OP_W-1]}}, mul_b});

  assign pow_p       = a_q + b_q - c_q;
  assign pow_shifted = pow_p >>> POW_SHIFT;

  always_comb begin
    pow_sat = POW_W'(pow_shifted);
    if (pow_shifted < 0)
      pow_sat = '0;
    else if (pow_shifted > POW_MAX)
      pow_sat = '1;
  end

  always_comb begin
    a_d    = (state_q == P1) ? mul : a_q;
    b_d    = (state_q == P2) ? mul : b_q;
    c_d    = (state_q == P3) ? mul : c_q;
    hold_d = (state_q == P4) ? pow_sat : hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      coeff_q   <= '0;
      snap_s1_q <= '0;
      snap_s2_q <= '0;
      snap_c_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      coeff_q   <= coeff_d;
      snap_s1_q <= snap_s1_d;
      snap_s2_q <= snap_s2_d;
      snap_c_q  <= snap_c_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      hold_q    <= hold_d;
    end
  end

  // A new start always wins, which keeps back-to-back short blocks intact.
  always_comb begin
    state_d = state_q;
    case (state_q)
      P1:      state_d = P2;
      P2:      state_d = P3;
      P3:      state_d = P4;
      P4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (last)
      state_d = P1;
  end

  always_comb begin
    power_valid = (state_q == P4);
    power_out   = power_valid ? pow_sat : hold_q;
  end

endmodule

// File: tb/tb_goertzel_filter.sv
// Self-checking bench for goertzel_filter: directed scenarios plus random blocks
// compared against a plain-arithmetic Goertzel reference.
module tb_goertzel_filter;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_in = 1'b0;
  logic signed [11:0] sample_in = '0;
  logic signed [15:0] coeff_in = '0;
  logic [31:0] power_out;
  logic        power_valid, busy;
  logic [15:0] power_out_s;
  logic        power_valid_s, busy_s;

  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;
  logic [31:0] got_q[$];
  logic [15:0] got_s_q[$];

  always #5 clk = ~clk;

  goertzel_filter #(.N(NB), .POW_W(32)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .sample_in(sample_in),
    .coeff_in(coeff_in), .power_out(power_out), .power_valid(power_valid), .busy(busy));

  goertzel_filter #(.N(NB), .POW_W(16)) dut_sat (
    .clk(clk), .rst(rst), .en_in(en_in), .sample_in(sample_in),
    .coeff_in(coeff_in), .power_out(power_out_s), .power_valid(power_valid_s), .busy(busy_s));

  always @(negedge clk) begin
    if (power_valid) begin
      pulses++;
      got_q.push_back(power_out);
    end
    if (power_valid_s)
      got_s_q.push_back(power_out_s);
  end

  function automatic logic signed [65:0] ref_power(input logic signed [15:0] c, input int smp[NB]);
    int s1, s2, w;
    logic signed [65:0] t1, t2, cs;
    s1 = 0;
    s2 = 0;
    for (int n = 0; n < NB; n++) begin
      w  = int'(longint'(smp[n]) + ((longint'(c) * longint'(s1)) >>> 14) - longint'(s2));
      s2 = s1;
      s1 = w;
    end
    t1 = s1;
    t2 = s2;
    cs = (longint'(c) * longint'(s1)) >>> 14;
    return t1 * t1 + t2 * t2 - cs * t2;
  endfunction

  function automatic logic [63:0] clamp(input logic signed [65:0] p, input int pw);
    logic signed [65:0] mx;
    mx = (66'sd1 <<< pw) - 66'sd1;
    if (p < 0) return 64'd0;
    if (p > mx) return mx[63:0];
    return p[63:0];
  endfunction

  // Caller sits at a negedge; returns at the following negedge with en_in low.
  task automatic send(input int x);
    en_in = 1'b1;
    sample_in = x[11:0];
    @(negedge clk);
    en_in = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!power_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    int r;
    n_total++;
    if ({power_out, power_valid, busy} !== 34'd0)
      $display("FAIL reset_initial: got out=%0d valid=%0b busy=%0b, want 0 0 0", power_out, power_valid, busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    coeff_in = 16'sd16384;
    @(negedge clk);
    for (int i = 0; i < NB + 2; i++) begin
      r = $urandom_range(0, 4095);
      send(r - 2048);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({power_out, power_valid, busy} !== 34'd0)
      $display("FAIL reset_async: got out=%0d valid=%0b busy=%0b, want 0 0 0", power_out, power_valid, busy);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en_in = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 4095);
      sample_in = r[11:0];
      #1;
      n_total++;
      if ({power_out, power_valid, busy} !== 34'd0)
        $display("FAIL reset_hold: got out=%0d valid=%0b busy=%0b, want 0 0 0", power_out, power_valid, busy);
      else n_pass++;
    end
    @(negedge clk);
    en_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_block(input string name, input int c, input int x0, input int x1,
                           input int x2, input int x3, input logic [31:0] exp, input int gap,
                           input bit zero_coeff_after_first);
    int smp[NB];
    int k, p0;
    smp = '{x0, x1, x2, x3};
    p0 = pulses;
    coeff_in = c[15:0];
    for (int i = 0; i < NB; i++) begin
      send(smp[i]);
      if (i == 0) begin
        if (zero_coeff_after_first) coeff_in = '0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s_busy_mid: got %0b want 1", name, busy);
        else n_pass++;
      end
      if (i < NB - 1) repeat (gap) @(negedge clk);
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_busy_end: got %0b want 0", name, busy);
    else n_pass++;
    wait_valid(k);
    n_total++;
    if (k !== 4) $display("FAIL %s_latency: got %0d cycles want 4", name, k);
    else n_pass++;
    n_total++;
    if (power_out !== exp) $display("FAIL %s_power: got %0d want %0d", name, power_out, exp);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (pulses - p0 !== 1) $display("FAIL %s_pulses: got %0d want 1", name, pulses - p0);
    else n_pass++;
    n_total++;
    if (power_out !== exp) $display("FAIL %s_hold: got %0d want %0d", name, power_out, exp);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_block("basic", 16384, 10, 10, 10, 10, 32'd300, 1000, 1'b1);
  endtask

  task automatic test_coeff_latch();
    run_block("latch_next", 0, 10, 10, 10, 10, 32'd0, 3, 1'b0);
  endtask

  task automatic test_coeff_zero();
    run_block("coeff0", 0, 1000, 0, 0, 0, 32'd1000000, 2, 1'b0);
  endtask

  task automatic test_saturation();
    run_block("sat_wide", 16384, 2047, 2047, 2047, 2047, 32'd12570627, 1, 1'b0);
    n_total++;
    if (power_out_s !== 16'd65535) $display("FAIL sat_narrow: got %0d want 65535", power_out_s);
    else n_pass++;
  endtask

  task automatic test_abort_back_to_back();
    got_q.delete();
    coeff_in = 16'sd16384;
    send(10);
    repeat (5) @(negedge clk);
    send(10);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %0b want 0", busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      send(10);
      if (i < NB - 1) repeat (1000) @(negedge clk);
    end
    for (int i = 0; i < NB; i++) send(10);
    repeat (10) @(negedge clk);
    n_total++;
    if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d pulses want 2", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_total++;
      if (got_q[i] !== 32'd300) $display("FAIL b2b_power%0d: got %0d want 300", i, got_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [15:0] exp_s_q[$];
    int smp[NB];
    logic signed [15:0] c;
    logic signed [65:0] p;
    logic [63:0] e;
    int r;
    got_q.delete();
    got_s_q.delete();
    for (int b = 0; b < 12; b++) begin
      r = $urandom_range(0, 65535);
      c = r[15:0];
      coeff_in = c;
      for (int i = 0; i < NB; i++) begin
        smp[i] = int'($urandom_range(0, 4095)) - 2048;
        send(smp[i]);
        r = $urandom_range(0, 65535);
        coeff_in = r[15:0];
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      p = ref_power(c, smp);
      e = clamp(p, 32);
      exp_q.push_back(e[31:0]);
      e = clamp(p, 16);
      exp_s_q.push_back(e[15:0]);
    end
    repeat (10) @(negedge clk);
    n_total++;
    if (got_q.size() !== exp_q.size() || got_s_q.size() !== exp_s_q.size())
      $display("FAIL rand_count: got %0d/%0d pulses want %0d", got_q.size(), got_s_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size() && i < got_s_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i] || got_s_q[i] !== exp_s_q[i])
        $display("FAIL rand_power%0d: got %0d/%0d want %0d/%0d", i, got_q[i], got_s_q[i], exp_q[i], exp_s_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coeff_latch();
    test_coeff_zero();
    test_saturation();
    test_abort_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
